// File: rtl/bomb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bomb_pkg                                                                   |
// | Shared coordinate width, bomb slot state encoding and blast hit test.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bomb_pkg;

    localparam int COORD_W = 4;

    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_ARMED = 2'd1;
    localparam logic [1:0] SLOT_BLAST = 2'd2;

    // Chebyshev test; one extra bit keeps the magnitude subtraction clean.
    function automatic logic cheb_hit(
        input logic [COORD_W-1:0] bx,
        input logic [COORD_W-1:0] by,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] r
    );
        logic [COORD_W:0] dx;
        logic [COORD_W:0] dy;
        dx = (bx >= px) ? ({1'b0, bx} - {1'b0, px}) : ({1'b0, px} - {1'b0, bx});
        dy = (by >= py) ? ({1'b0, by} - {1'b0, py}) : ({1'b0, py} - {1'b0, by});
        return (dx <= {1'b0, r}) && (dy <= {1'b0, r});
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bomb_slot                                                                  |
// | One player's bomb: arms on a drop, runs the fuse, emits a 1-cycle blast.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               drop,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               act,
    output logic               blast,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y
);

    localparam int FUSE_W = (FUSE_TICKS > 2) ? $clog2(FUSE_TICKS) : 1;
    localparam logic [FUSE_W-1:0] FUSE_LOAD = FUSE_W'(FUSE_TICKS - 1);
    localparam logic [FUSE_W-1:0] FUSE_ONE  = FUSE_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [FUSE_W-1:0] fuse;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fuse holds the number of ARMED cycles still to run, so the last one ends at 1.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_IDLE:  if (drop) state_next = SLOT_ARMED;
            SLOT_ARMED: if (fuse == FUSE_ONE) state_next = SLOT_BLAST;
            SLOT_BLAST: state_next = SLOT_IDLE;
            default:    state_next = SLOT_IDLE;
        endcase
    end

    always_comb begin
        act   = (state == SLOT_ARMED) || (state == SLOT_BLAST);
        blast = (state == SLOT_BLAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fuse   <= '0;
            bomb_x <= '0;
            bomb_y <= '0;
        end else if (state == SLOT_IDLE && drop) begin
            fuse   <= FUSE_LOAD;
            bomb_x <= x;
            bomb_y <= y;
        end else if (state == SLOT_ARMED && fuse != '0) begin
            fuse <= fuse - FUSE_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bomb_blast_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bomb_blast_resolver                                                        |
// | Two bomb slots, cross-wired blast hit tests and per-player stun timers.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bomb_blast_resolver
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS   = 500,
    parameter int STUN_TICKS   = 1000,
    parameter int BLAST_RADIUS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               red_drop_i,
    input  logic [COORD_W-1:0] red_x_i,
    input  logic [COORD_W-1:0] red_y_i,
    input  logic               blue_drop_i,
    input  logic [COORD_W-1:0] blue_x_i,
    input  logic [COORD_W-1:0] blue_y_i,
    output logic               red_stun_o,
    output logic               blue_stun_o,
    output logic               red_bomb_act_o,
    output logic [COORD_W-1:0] red_bomb_x_o,
    output logic [COORD_W-1:0] red_bomb_y_o,
    output logic               blue_bomb_act_o,
    output logic [COORD_W-1:0] blue_bomb_x_o,
    output logic [COORD_W-1:0] blue_bomb_y_o,
    output logic               red_blast_o,
    output logic               blue_blast_o
);

    localparam int STUN_W = (STUN_TICKS > 1) ? $clog2(STUN_TICKS + 1) : 1;
    localparam logic [STUN_W-1:0]  STUN_LOAD = STUN_W'(STUN_TICKS);
    localparam logic [COORD_W-1:0] RADIUS    = COORD_W'(BLAST_RADIUS);

    logic              red_hits_blue;
    logic              blue_hits_red;
    logic [STUN_W-1:0] red_stun_cnt;
    logic [STUN_W-1:0] blue_stun_cnt;

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_red_slot (
        .clk    (clk),
        .reset  (reset),
        .drop   (red_drop_i),
        .x      (red_x_i),
        .y      (red_y_i),
        .act    (red_bomb_act_o),
        .blast  (red_blast_o),
        .bomb_x (red_bomb_x_o),
        .bomb_y (red_bomb_y_o)
    );

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_blue_slot (
        .clk    (clk),
        .reset  (reset),
        .drop   (blue_drop_i),
        .x      (blue_x_i),
        .y      (blue_y_i),
        .act    (blue_bomb_act_o),
        .blast  (blue_blast_o),
        .bomb_x (blue_bomb_x_o),
        .bomb_y (blue_bomb_y_o)
    );

    // Each bomb is tested only against the opponent's live position.
    always_comb begin
        red_hits_blue = red_blast_o &&
            cheb_hit(red_bomb_x_o, red_bomb_y_o, blue_x_i, blue_y_i, RADIUS);
        blue_hits_red = blue_blast_o &&
            cheb_hit(blue_bomb_x_o, blue_bomb_y_o, red_x_i, red_y_i, RADIUS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_stun_cnt  <= '0;
            blue_stun_cnt <= '0;
        end else begin
            if (blue_hits_red) begin
                red_stun_cnt <= STUN_LOAD;
            end else if (red_stun_cnt != '0) begin
                red_stun_cnt <= red_stun_cnt - 1'b1;
            end
            if (red_hits_blue) begin
                blue_stun_cnt <= STUN_LOAD;
            end else if (blue_stun_cnt != '0) begin
                blue_stun_cnt <= blue_stun_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        red_stun_o  = (red_stun_cnt != '0);
        blue_stun_o = (blue_stun_cnt != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_bomb_blast_resolver.sv
`default_nettype none
// Bench for bomb_blast_resolver: directed scenarios plus random traffic against
// an event-time model (blast edge and last stunned edge per player).
module tb_bomb_blast_resolver;

    localparam int F = 4;
    localparam int S = 6;
    localparam int R = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       red_drop, blue_drop;
    logic [3:0] red_x, red_y, blue_x, blue_y;
    logic       red_stun, blue_stun, red_act, blue_act, red_blast, blue_blast;
    logic [3:0] rbx, rby, bbx, bby;

    int tests = 0;
    int fails = 0;

    // Model: edge count, armed flag, edge after which the blast is visible,
    // latched bomb position, last edge after which the player is still stunned.
    int         e = 0;
    bit         am [2];
    int         be [2];
    logic [3:0] mx [2];
    logic [3:0] my [2];
    int         sl [2];

    bomb_blast_resolver #(
        .FUSE_TICKS  (F),
        .STUN_TICKS  (S),
        .BLAST_RADIUS(R)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .red_drop_i     (red_drop),
        .red_x_i        (red_x),
        .red_y_i        (red_y),
        .blue_drop_i    (blue_drop),
        .blue_x_i       (blue_x),
        .blue_y_i       (blue_y),
        .red_stun_o     (red_stun),
        .blue_stun_o    (blue_stun),
        .red_bomb_act_o (red_act),
        .red_bomb_x_o   (rbx),
        .red_bomb_y_o   (rby),
        .blue_bomb_act_o(blue_act),
        .blue_bomb_x_o  (bbx),
        .blue_bomb_y_o  (bby),
        .red_blast_o    (red_blast),
        .blue_blast_o   (blue_blast)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_edge();
        logic [3:0] px [2];
        logic [3:0] py [2];
        bit drp [2];
        bit ended [2];
        e++;
        px[0] = red_x;  py[0] = red_y;  drp[0] = red_drop;
        px[1] = blue_x; py[1] = blue_y; drp[1] = blue_drop;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                am[p] = 0; be[p] = -10; mx[p] = 4'd0; my[p] = 4'd0; sl[p] = -1;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                ended[p] = 0;
                if (am[p] && be[p] == e - 1) begin
                    if (iabs(int'(mx[p]) - int'(px[1-p])) <= R &&
                        iabs(int'(my[p]) - int'(py[1-p])) <= R)
                        sl[1-p] = e + S - 1;
                    am[p]    = 0;
                    ended[p] = 1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!am[p] && !ended[p] && drp[p]) begin
                    am[p] = 1; mx[p] = px[p]; my[p] = py[p]; be[p] = e + F - 1;
                end
            end
        end
    endtask

    function automatic logic [21:0] exp_vec();
        return {e <= sl[0], e <= sl[1], am[0], mx[0], my[0], am[1], mx[1], my[1],
                am[0] && (e == be[0]), am[1] && (e == be[1])};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {red_stun, blue_stun, red_act, rbx, rby, blue_act, bbx, bby,
                red_blast, blue_blast};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        red_drop = 0; blue_drop = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1; red_drop = 0; blue_drop = 0;
        red_x = 0; red_y = 0; blue_x = 0; blue_y = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (dut_vec() !== 22'h0 || exp_vec() !== 22'h0) begin
                fails++;
                $display("FAIL reset edge %0d: got %h want 000000", e, dut_vec());
            end
        end
        reset = 0;
    endtask

    task automatic test_scenario1();
        int nact = 0, nblast = 0, bl_at = -1, nbs = 0, nrs = 0;
        idle(12);
        red_x = 3; red_y = 3; blue_x = 4; blue_y = 4;
        red_drop = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            red_drop = 0;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL s1 edge %0d: got %h want %h", e, dut_vec(), exp_vec());
            end
            nact += int'(red_act); nblast += int'(red_blast);
            nbs += int'(blue_stun); nrs += int'(red_stun);
            if (red_blast) bl_at = c;
        end
        tests++;
        if (nact != 4 || nblast != 1 || bl_at != 3) begin
            fails++;
            $display("FAIL s1_timing: act=%0d blast=%0d at=%0d want 4 1 3", nact, nblast, bl_at);
        end
        tests++;
        if (nbs != 6 || nrs != 0) begin
            fails++;
            $display("FAIL s1_stun: blue=%0d red=%0d want 6 0", nbs, nrs);
        end
    endtask

    task automatic test_miss_then_hit();
        for (int run = 0; run < 2; run++) begin
            int nblast = 0, nbs = 0;
            idle(12);
            red_x = 3; red_y = 3; blue_x = 4; blue_y = 4;
            red_drop = 1;
            for (int c = 0; c < 12; c++) begin
                tick();
                red_drop = 0;
                if (c == 0) begin
                    blue_x = (run == 0) ? 4'd5 : 4'd2;
                    blue_y = (run == 0) ? 4'd3 : 4'd2;
                end
                tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL s2 run %0d edge %0d: got %h want %h", run, e, dut_vec(), exp_vec());
                end
                nblast += int'(red_blast); nbs += int'(blue_stun);
            end
            tests++;
            if (nblast != 1 || nbs != ((run == 0) ? 0 : 6)) begin
                fails++;
                $display("FAIL s2_result run %0d: blast=%0d stun=%0d", run, nblast, nbs);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int run = 0; run < 2; run++) begin
            int both = 0, nbs = 0, nrs = 0;
            idle(12);
            red_x  = (run == 0) ? 4'd0 : 4'd10; red_y  = (run == 0) ? 4'd0 : 4'd10;
            blue_x = (run == 0) ? 4'd10 : 4'd0; blue_y = (run == 0) ? 4'd10 : 4'd0;
            red_drop = 1; blue_drop = 1;
            for (int c = 0; c < 12; c++) begin
                tick();
                red_drop = 0; blue_drop = 0;
                if (c == 0) begin
                    if (run == 0) begin blue_x = 1; blue_y = 0; end
                    else begin red_x = 1; red_y = 0; end
                end
                tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL s3 run %0d edge %0d: got %h want %h", run, e, dut_vec(), exp_vec());
                end
                both += int'(red_blast && blue_blast);
                nbs += int'(blue_stun); nrs += int'(red_stun);
            end
            tests++;
            if (both != 1 || nbs != ((run == 0) ? 6 : 0) || nrs != ((run == 0) ? 0 : 6)) begin
                fails++;
                $display("FAIL s3_result run %0d: both=%0d blue=%0d red=%0d", run, both, nbs, nrs);
            end
        end
    endtask

    task automatic test_redrop_ignored();
        int nblast = 0, bad_xy = 0;
        idle(12);
        red_x = 3; red_y = 3; blue_x = 12; blue_y = 12;
        red_drop = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            red_drop = (c == 1);
            if (c == 0) begin red_x = 9; red_y = 9; end
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL s4 edge %0d: got %h want %h", e, dut_vec(), exp_vec());
            end
            nblast += int'(red_blast);
            if (red_act && (rbx !== 4'd3 || rby !== 4'd3)) bad_xy++;
        end
        tests++;
        if (nblast != 1 || bad_xy != 0) begin
            fails++;
            $display("FAIL s4_result: blast=%0d bad_xy=%0d want 1 0", nblast, bad_xy);
        end
    endtask

    task automatic test_stun_extend();
        int first = -1, last = -1, ones = 0;
        bit seen = 0;
        idle(12);
        red_x = 3; red_y = 3; blue_x = 3; blue_y = 4;
        red_drop = 1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            red_drop = 0;
            seen = red_blast;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL s5_wait: red_blast never seen, got 0 want 1");
        end
        for (int c = 0; c < 16; c++) begin
            red_drop = (c == 1);
            tick();
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL s5 edge %0d: got %h want %h", e, dut_vec(), exp_vec());
            end
            if (blue_stun) begin
                ones++; last = c;
                if (first < 0) first = c;
            end
        end
        red_drop = 0;
        tests++;
        if (ones != 11 || (last - first + 1) != ones) begin
            fails++;
            $display("FAIL s5_extend: stun cycles=%0d span=%0d want 11 11", ones, last - first + 1);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        idle(12);
        red_x = 3; red_y = 3; blue_x = 4; blue_y = 4;
        red_drop = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            red_drop = (c == 4);
        end
        red_drop = 0;
        reset = 1;
        tick();
        reset = 0;
        tests++;
        if (dut_vec() !== 22'h0) begin
            fails++;
            $display("FAIL s6_reset: got %h want 000000", dut_vec());
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dut_vec() !== 22'h0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL s6_quiet: nonzero cycles=%0d want 0", stray);
        end
        test_scenario1();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            red_drop  = ($urandom_range(0, 5) == 0);
            blue_drop = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                red_x  = 4'($urandom_range(0, 15)); red_y  = 4'($urandom_range(0, 15));
                blue_x = 4'($urandom_range(0, 15)); blue_y = 4'($urandom_range(0, 15));
            end else begin
                red_x  = 4'($urandom_range(0, 3)); red_y  = 4'($urandom_range(0, 3));
                blue_x = 4'($urandom_range(0, 3)); blue_y = 4'($urandom_range(0, 3));
            end
            tick();
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random edge %0d: got %h want %h", e, dut_vec(), exp_vec());
            end
        end
        reset = 0; red_drop = 0; blue_drop = 0;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            am[p] = 0; be[p] = -10; mx[p] = 4'd0; my[p] = 4'd0; sl[p] = -1;
        end
        test_reset();
        test_scenario1();
        test_miss_then_hit();
        test_simultaneous();
        test_redrop_ignored();
        test_stun_extend();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
